// File: rtl/relu_pool_layer_pkg.sv
// Shared types and constants for the ReLU + max-pool layer.
// Holds the FSM encoding, default geometry and a width helper.
package relu_pool_layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_H          = 6;
    localparam int DEF_W          = 6;
    localparam int DEF_P          = 2;

    localparam int POOL_H = DEF_H / DEF_P;
    localparam int POOL_W = DEF_W / DEF_P;
    localparam int N      = POOL_H * POOL_W;
    localparam int WIN    = DEF_P * DEF_P;

    // Counter width for a range of n values; never narrower than 1 bit.
    function automatic int cbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_pool_layer_pool_max_unit.sv
// Registered running signed maximum over one pooling window.
// Ports: clk, rst_ni (sync, active-low), clear_i, en_i, elem_i -> max_o.
module relu_pool_layer_pool_max_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] elem_i,
    output logic signed [DATA_WIDTH-1:0] max_o
);

    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] acc_d;

    // max_o is the value including the current element, so the caller
    // can store a finished window in the same cycle as its last element.
    always_comb begin
        acc_d = (elem_i > acc_q) ? elem_i : acc_q;
        max_o = acc_d;
    end

    // Clearing to zero (not to the first element) folds ReLU into the max.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/relu_pool_layer.sv
// ReLU followed by PxP stride-P max pooling, one element per clock.
// Ports: clk, reset (sync, active-low), start, featureMap -> outputPool, busy, done.
module relu_pool_layer
    import relu_pool_layer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int H          = DEF_H,
    parameter int W          = DEF_W,
    parameter int P          = DEF_P
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [0:H*W*DATA_WIDTH-1]               featureMap,
    output logic [0:(H/P)*(W/P)*DATA_WIDTH-1]       outputPool,
    output logic                                    busy,
    output logic                                    done
);

    localparam int PH    = H / P;
    localparam int PW    = W / P;
    localparam int NS    = PH * PW;
    localparam int ELEMS = H * W;
    localparam int AW    = cbits(ELEMS);
    localparam int IW    = cbits(NS);
    localparam int PRW   = cbits(PH);
    localparam int PCW   = cbits(PW);
    localparam int KW    = cbits(P);

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] fmap_q [ELEMS];
    logic signed [DATA_WIDTH-1:0] pool_q [NS];

    logic [IW-1:0]  idx_q;
    logic [PRW-1:0] pr_q;
    logic [PCW-1:0] pc_q;
    logic [KW-1:0]  kr_q;
    logic [KW-1:0]  kc_q;

    logic [AW-1:0]                addr;
    logic signed [DATA_WIDTH-1:0] elem;
    logic signed [DATA_WIDTH-1:0] win_max;
    logic                         launch;
    logic                         win_last;
    logic                         map_last;

    assign launch   = (state_q == IDLE) && start;
    assign win_last = (kr_q == KW'(P - 1)) && (kc_q == KW'(P - 1));
    assign map_last = (pr_q == PRW'(PH - 1)) && (pc_q == PCW'(PW - 1));

    // Row/column counters replace idx/(W/P) and k%P to avoid dividers.
    always_comb begin
        addr = AW'((int'(pr_q) * P + int'(kr_q)) * W
                   + int'(pc_q) * P + int'(kc_q));
        elem = fmap_q[addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (win_last && map_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q <= '0;
            pr_q  <= '0;
            pc_q  <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
            for (int i = 0; i < ELEMS; i++) fmap_q[i] <= '0;
            for (int i = 0; i < NS; i++) pool_q[i] <= '0;
        end else if (launch) begin
            idx_q <= '0;
            pr_q  <= '0;
            pc_q  <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
            for (int i = 0; i < ELEMS; i++) begin
                fmap_q[i] <= featureMap[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int i = 0; i < NS; i++) pool_q[i] <= '0;
        end else if (state_q == RUN) begin
            if (win_last) begin
                pool_q[idx_q] <= win_max;
                kr_q <= '0;
                kc_q <= '0;
                if (!map_last) begin
                    idx_q <= idx_q + 1'b1;
                    if (pc_q == PCW'(PW - 1)) begin
                        pc_q <= '0;
                        pr_q <= pr_q + 1'b1;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
            end else if (kc_q == KW'(P - 1)) begin
                kc_q <= '0;
                kr_q <= kr_q + 1'b1;
            end else begin
                kc_q <= kc_q + 1'b1;
            end
        end
    end

    relu_pool_layer_pool_max_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_max (
        .clk     (clk),
        .rst_ni  (reset),
        .clear_i (launch || ((state_q == RUN) && win_last)),
        .en_i    (state_q == RUN),
        .elem_i  (elem),
        .max_o   (win_max)
    );

    for (genvar g = 0; g < NS; g++) begin : g_out
        assign outputPool[g*DATA_WIDTH +: DATA_WIDTH] = pool_q[g];
    end

endmodule

// File: tb/tb_relu_pool_layer.sv
// Scoreboard bench for relu_pool_layer: directed and random maps.
// Expected pools come from a window-max model; a monitor checks on done.
module tb_relu_pool_layer;

    localparam int DW   = 8;
    localparam int H    = 6;
    localparam int W    = 6;
    localparam int P    = 2;
    localparam int PH   = H / P;
    localparam int PW   = W / P;
    localparam int NS   = PH * PW;
    localparam int NE   = H * W;
    localparam int RUNC = NS * P * P;

    typedef logic signed [DW-1:0] map_t [NE];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [0:NE*DW-1]  featureMap = '0;
    logic [0:NS*DW-1]  outputPool;
    logic              busy;
    logic              done;

    relu_pool_layer #(
        .DATA_WIDTH (DW),
        .H          (H),
        .W          (W),
        .P          (P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .featureMap (featureMap),
        .outputPool (outputPool),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [0:NS*DW-1] exp_pool_q [$];
    int               exp_edge_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [0:NE*DW-1] pack(input map_t m);
        logic [0:NE*DW-1] v;
        for (int i = 0; i < NE; i++) v[i*DW +: DW] = m[i];
        return v;
    endfunction

    // Each pooled pixel is max(0, max of its PxP window), in plain ints.
    function automatic logic [0:NS*DW-1] model(input map_t m);
        logic [0:NS*DW-1] v;
        int best, e;
        for (int pr = 0; pr < PH; pr++) begin
            for (int pc = 0; pc < PW; pc++) begin
                best = 0;
                for (int kr = 0; kr < P; kr++) begin
                    for (int kc = 0; kc < P; kc++) begin
                        e = int'(m[(pr*P + kr)*W + pc*P + kc]);
                        if (e > best) best = e;
                    end
                end
                v[(pr*PW + pc)*DW +: DW] = best[DW-1:0];
            end
        end
        return v;
    endfunction

    int busy_cnt  = 0;
    bit prev_done = 1'b0;

    always @(negedge clk) begin
        logic [0:NS*DW-1] ev;
        int               ee;
        if (!reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_done) chk("done_one_cycle", int'(done), 0);
            if (done) begin
                if (exp_pool_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    ev = exp_pool_q.pop_front();
                    ee = exp_edge_q.pop_front();
                    for (int i = 0; i < NS; i++) begin
                        chk($sformatf("slot%0d", i),
                            int'(outputPool[i*DW +: DW]),
                            int'(ev[i*DW +: DW]));
                    end
                    chk("done_cycle", cyc, ee);
                    chk("busy_cycles", busy_cnt, RUNC);
                    chk("busy_in_done", int'(busy), 0);
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    // chg_at: negedge after start at which the input map is scribbled.
    // abort_at: negedge after start at which reset is pulsed (no done).
    task automatic run(input map_t m, input int chg_at, input int abort_at);
        int t0;
        bit seen;
        @(negedge clk);
        featureMap = pack(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            chk("abort_pool_nonzero", int'(outputPool != '0), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            reset = 1'b1;
            repeat (RUNC + 5) @(negedge clk);
            chk("abort_still_idle", int'(busy), 0);
            return;
        end
        exp_pool_q.push_back(model(m));
        exp_edge_q.push_back(t0 + RUNC);
        seen = 1'b0;
        for (int c = 1; c <= RUNC + 20; c++) begin
            @(negedge clk);
            if (c == chg_at) featureMap = {NE{8'h7F}};
            if (exp_pool_q.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            exp_pool_q.delete();
            exp_edge_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        map_t m;
        map_t ramp;

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                ramp[r*W + c] = DW'(r*W + c);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pool_nonzero", int'(outputPool != '0), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NE; i++) m[i] = 8'sh05;
        run(m, -1, -1);

        for (int i = 0; i < NE; i++) m[i] = 8'shFD;
        run(m, -1, -1);

        run(ramp, -1, -1);

        for (int i = 0; i < NE; i++) m[i] = 8'sh01;
        m[0] = 8'sh80;
        m[1] = 8'sh7F;
        m[6] = 8'shFF;
        m[7] = 8'sh00;
        m[2] = 8'sh80;
        m[3] = 8'sh80;
        m[8] = 8'sh80;
        m[9] = 8'sh80;
        run(m, -1, -1);

        run(ramp, 5, -1);

        run(ramp, -1, 10);
        run(ramp, -1, -1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NE; i++) begin
                if (t % 3 == 0)
                    m[i] = DW'($urandom_range(120, 136));
                else
                    m[i] = DW'($urandom);
            end
            run(m, (t % 2 == 1) ? int'($urandom_range(1, RUNC - 1)) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/relu_pool_layer.md
Name: relu_pool_layer

Overview:
- Downstream stage of the single-channel convolution layer.
- Consumes the flat signed feature map the convolution layer produces (default 6x6 for an 8x8 image and a 3x3 kernel).
- Applies ReLU followed by PxP max pooling with stride P.
- Serial datapath: one feature element per clock, one pooled pixel every P*P clocks, written into a flat output vector for the next layer.

Parameters:
- DATA_WIDTH, 8, bits per element; signed two's complement.
- H, 6, feature map height (equals the conv layer's H-F+1).
- W, 6, feature map width (equals the conv layer's W-F+1).
- P, 2, pooling window size and stride.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- featureMap  input  H*W*DATA_WIDTH, indexed [0:H*W*DATA_WIDTH-1]  row-major feature map; element (r,c) at [(r*W+c)*DATA_WIDTH +: DATA_WIDTH].
- outputPool  output  (H/P)*(W/P)*DATA_WIDTH, indexed [0:...]  row-major pooled map; pooled pixel i at [i*DATA_WIDTH +: DATA_WIDTH].
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse when all pooled pixels are written.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - outputPool=0, busy=0, done=0.
  - Internal counters, accumulator and captured map all cleared.
  - Applies in any state: a run in progress is abandoned and done is not pulsed.
- Constants:
  - N = (H/P)*(W/P), integer division.
  - Trailing rows and columns that do not fill a full window are ignored.
- IDLE, start==1:
  - Capture featureMap into an internal register; later changes on the input have no effect on this run.
  - Clear outputPool to 0; idx=0, k=0, acc=0; go to RUN.
- RUN, one element per cycle:
  - Element address: pr=idx/(W/P), pc=idx%(W/P), kr=k/P, kc=k%P; element (pr*P+kr, pc*P+kc).
  - acc_next = max(acc, element), signed compare.
  - acc starts at 0 for each window, so the result is max(0, window max), i.e. ReLU folded into the pooling.
  - k<P*P-1: k++.
  - k==P*P-1:
    - Write acc_next into slot idx of outputPool; acc=0; k=0.
    - idx==N-1: go to DONE. Otherwise idx++.
  - start is ignored in RUN.
- DONE: done=1 for exactly this cycle, busy=0, next state IDLE.
- Latency: start sampled at edge t; RUN occupies N*P*P cycles; done is high in cycle t+N*P*P+1.
  - Default: 36 RUN cycles, done in cycle 37.
- Output visibility:
  - Pooled slot i is updated the cycle its last element is consumed.
  - outputPool holds its value from DONE until the next start or reset.
- start held high:
  - A new run begins on the first IDLE cycle after DONE.
  - start asserted on the same edge as reset==0 is lost.
- Arithmetic:
  - Signed DATA_WIDTH compare, no widening, no saturation.
  - Outputs are always >= 0. Positive values pass through unchanged; -128 becomes 0.

Decomposition:
- Shared package/include holds:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Derived constants: POOL_H=H/P, POOL_W=W/P, N, WIN=P*P.
- Sub-module pool_max_unit (natural):
  - Registered running signed max over one window.
  - Inputs clear/enable/element; output the accumulated max.
  - Parallels the existing per-window convolution unit.

Test Plan:
- Uniform map, all 5 (0x05), start pulse -> busy high 36 cycles; done pulse in cycle 37; all 9 outputPool slots = 5; done low again next cycle.
- All elements -3 (0xFD) -> all 9 slots = 0 (ReLU); done timing unchanged.
- Ramp map, value r*6+c (0..35) -> outputPool = 7,9,11,19,21,23,31,33,35.
- Signed extremes: window 0 = {-128,127,-1,0}, window 1 = {-128,-128,-128,-128}, rest 1 -> slot0=127, slot1=0, others=1.
- Input stability: start with the ramp, change featureMap to all 0x7F at RUN cycle 5 -> results still the ramp values above.
- Reset mid-operation: reset=0 at RUN cycle 10 -> next cycle outputPool=0, busy=0, no done. Then start with the ramp -> correct ramp results, done at cycle 37.
